// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle radix-2 restoring divider, one quotient bit per clock.
//   Handles signed (two's-complement) and unsigned operands per operation,
//   flags divide-by-zero and signed overflow (MIN / -1), truncates toward zero
//   and gives the remainder the sign of the dividend. Operands are latched on
//   the start edge, so the inputs may change freely afterwards.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        launch request, honoured only while busy is low
//   signed_op    1: signed operation, 0: unsigned (sampled with start)
//   abort        cancels an operation in CALC or FIX; outputs are kept
//   dividend     numerator (sampled with start)
//   divisor      denominator (sampled with start)
//   busy         operation in flight
//   done         one-cycle pulse, results valid from this cycle on
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
//   div_by_zero  divisor was zero for the last completed operation
//   overflow     signed MIN / -1 for the last completed operation
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_W     = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_r;
    state_t           state_nxt_s;

    logic [WIDTH-1:0] rem_r;       // upper half of the partial remainder
    logic [WIDTH-1:0] quo_r;       // lower half: dividend bits shifting out, quotient bits in
    logic [WIDTH-1:0] dvsr_r;      // divisor magnitude
    logic [CNT_W-1:0] cnt_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             ovf_r;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;
    logic             overflow_r;

    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] a_abs_s;
    logic [WIDTH-1:0] b_abs_s;
    logic [WIDTH:0]   shifted_s;
    logic             trial_ok_s;
    logic [WIDTH-1:0] trial_s;

    // Operand magnitudes and one restoring-division step
    always_comb begin
        a_neg_s    = signed_op & dividend[WIDTH-1];
        b_neg_s    = signed_op & divisor[WIDTH-1];
        // |MIN| wraps to MIN, which read as unsigned is the correct magnitude
        a_abs_s    = a_neg_s ? (ZERO_W - dividend) : dividend;
        b_abs_s    = b_neg_s ? (ZERO_W - divisor) : divisor;
        shifted_s  = {rem_r, quo_r[WIDTH-1]};
        trial_ok_s = (shifted_s >= {1'b0, dvsr_r});
        // When the trial succeeds the true difference is below dvsr_r, so the
        // low WIDTH bits of the subtraction are exact
        trial_s    = shifted_s[WIDTH-1:0] - dvsr_r;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (divisor == ZERO_W) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r == LAST_ITER) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            FIX: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath, result registers and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r       <= ZERO_W;
            quo_r       <= ZERO_W;
            dvsr_r      <= ZERO_W;
            cnt_r       <= CNT_ZERO;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            ovf_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= ZERO_W;
            remainder_r <= ZERO_W;
            dbz_r       <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != IDLE);
            // done follows the DONE state by one edge, coinciding with busy falling
            done_r <= (state_r == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (divisor == ZERO_W) begin
                            quotient_r  <= ONES_W;
                            remainder_r <= dividend;
                            dbz_r       <= 1'b1;
                            overflow_r  <= 1'b0;
                        end else begin
                            rem_r   <= ZERO_W;
                            quo_r   <= a_abs_s;
                            dvsr_r  <= b_abs_s;
                            cnt_r   <= CNT_ZERO;
                            neg_q_r <= a_neg_s ^ b_neg_s;
                            neg_r_r <= a_neg_s;
                            ovf_r   <= signed_op & (dividend == MIN_W) & (divisor == ONES_W);
                        end
                    end
                end
                CALC: begin
                    if (!abort) begin
                        rem_r <= trial_ok_s ? trial_s : shifted_s[WIDTH-1:0];
                        quo_r <= {quo_r[WIDTH-2:0], trial_ok_s};
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                FIX: begin
                    if (!abort) begin
                        quotient_r  <= neg_q_r ? (ZERO_W - quo_r) : quo_r;
                        remainder_r <= neg_r_r ? (ZERO_W - rem_r) : rem_r;
                        dbz_r       <= 1'b0;
                        overflow_r  <= ovf_r;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Drives a 64-bit and an 8-bit seq_divider with directed and random
//   operations and compares every result, flag and latency against a plain
//   arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start_a;
    logic        start_b;
    logic        signed_op;
    logic        abort;
    logic [63:0] dividend;
    logic [63:0] divisor;

    logic        busy_a, done_a, dbz_a, ovf_a;
    logic [63:0] q_a, r_a;
    logic        busy_b, done_b, dbz_b, ovf_b;
    logic [7:0]  q_b, r_b;

    bit          sel8;
    logic [63:0] cur_q, cur_r;
    logic        cur_busy, cur_done, cur_dbz, cur_ovf;

    int          total;
    int          bad;

    seq_divider #(.WIDTH(64), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .signed_op(signed_op),
        .abort(abort), .dividend(dividend), .divisor(divisor),
        .busy(busy_a), .done(done_a), .quotient(q_a), .remainder(r_a),
        .div_by_zero(dbz_a), .overflow(ovf_a)
    );

    seq_divider #(.WIDTH(8), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .signed_op(signed_op),
        .abort(abort), .dividend(dividend[7:0]), .divisor(divisor[7:0]),
        .busy(busy_b), .done(done_b), .quotient(q_b), .remainder(r_b),
        .div_by_zero(dbz_b), .overflow(ovf_b)
    );

    assign cur_q    = sel8 ? {56'd0, q_b} : q_a;
    assign cur_r    = sel8 ? {56'd0, r_b} : r_a;
    assign cur_busy = sel8 ? busy_b : busy_a;
    assign cur_done = sel8 ? done_b : done_a;
    assign cur_dbz  = sel8 ? dbz_b : dbz_a;
    assign cur_ovf  = sel8 ? ovf_b : ovf_a;

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: truncating division of w-bit operands, computed with 64-bit arithmetic
    task automatic ref_div(input int w, input bit sg, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] q, output logic [63:0] r,
                           output logic dbz, output logic ovf);
        logic [63:0] mask;
        logic [63:0] tmp;
        longint      sa, sb, minv;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        dbz  = 1'b0;
        ovf  = 1'b0;
        if (b == 64'd0) begin
            q   = mask;
            r   = a;
            dbz = 1'b1;
        end else if (sg) begin
            tmp  = a << (64 - w);
            sa   = $signed(tmp) >>> (64 - w);
            tmp  = b << (64 - w);
            sb   = $signed(tmp) >>> (64 - w);
            minv = longint'(64'hFFFF_FFFF_FFFF_FFFF << (w - 1));
            if (sa == minv && sb == -64'sd1) begin
                q   = a;
                r   = 64'd0;
                ovf = 1'b1;
            end else begin
                q = 64'(sa / sb) & mask;
                r = 64'(sa % sb) & mask;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // One complete operation on the selected DUT, checking result, flags, latency and busy
    task automatic do_op(input bit s8, input bit sg, input logic [63:0] a_in,
                         input logic [63:0] b_in, input int restart_at, input bit ab_start);
        int          w, lat, n;
        logic [63:0] mask, a, b, eq, er;
        logic        edbz, eovf;
        bit          busy_ok, got_done;
        w    = s8 ? 8 : 64;
        mask = s8 ? 64'h0000_0000_0000_00FF : 64'hFFFF_FFFF_FFFF_FFFF;
        a    = a_in & mask;
        b    = b_in & mask;
        ref_div(w, sg, a, b, eq, er, edbz, eovf);
        lat  = (b == 64'd0) ? 1 : w + 2;
        @(negedge clk);
        sel8      = s8;
        signed_op = sg;
        dividend  = a;
        divisor   = b;
        abort     = ab_start;
        if (s8) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a   = 1'b0;
        start_b   = 1'b0;
        abort     = 1'b0;
        dividend  = {$urandom, $urandom};
        divisor   = {$urandom, $urandom};
        signed_op = 1'($urandom);
        check_val("busy_rise", 64'(cur_busy), 64'd1);
        n        = 0;
        busy_ok  = 1'b1;
        got_done = 1'b0;
        while (!got_done && n < w + 10) begin
            @(posedge clk);
            #1;
            n++;
            if (cur_done) begin
                got_done = 1'b1;
            end else if (!cur_busy) begin
                busy_ok = 1'b0;
            end
            if (n == restart_at) begin
                if (s8) start_b = 1'b1; else start_a = 1'b1;
            end else begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
        check_val("latency", 64'(n), 64'(lat));
        check_val("busy_held", 64'(busy_ok), 64'd1);
        check_val("busy_fall", 64'(cur_busy), 64'd0);
        check_val("quotient", cur_q, eq);
        check_val("remainder", cur_r, er);
        check_val("div_by_zero", 64'(cur_dbz), 64'(edbz));
        check_val("overflow", 64'(cur_ovf), 64'(eovf));
        @(posedge clk);
        #1;
        check_val("done_pulse", 64'(cur_done), 64'd0);
    endtask

    // Start a 64-bit op, abort it k edges after the start edge, expect old outputs kept
    task automatic abort_test(input int k, input logic [63:0] hq, input logic [63:0] hr);
        bit seen;
        @(negedge clk);
        sel8      = 1'b0;
        signed_op = 1'b0;
        dividend  = 64'd999;
        divisor   = 64'd3;
        start_a   = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (k) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_val("abort_busy", 64'(busy_a), 64'd0);
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (done_a) seen = 1'b1;
        end
        check_val("abort_no_done", 64'(seen), 64'd0);
        check_val("abort_q_held", q_a, hq);
        check_val("abort_r_held", r_a, hr);
    endtask

    initial begin
        logic [63:0] ra, rb;
        int          mode;
        total     = 0;
        bad       = 0;
        sel8      = 1'b0;
        rst_n     = 1'b0;
        start_a   = 1'b0;
        start_b   = 1'b0;
        signed_op = 1'b0;
        abort     = 1'b0;
        dividend  = 64'd0;
        divisor   = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", 64'(busy_a), 64'd0);
        check_val("rst_done", 64'(done_a), 64'd0);
        check_val("rst_q", q_a, 64'd0);
        check_val("rst_r", r_a, 64'd0);
        check_val("rst_dbz", 64'(dbz_a), 64'd0);
        check_val("rst_ovf", 64'(ovf_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed 64-bit cases
        do_op(1'b0, 1'b0, 64'd100, 64'd7, 0, 1'b0);
        do_op(1'b0, 1'b1, -64'sd7, 64'd2, 0, 1'b0);
        do_op(1'b0, 1'b1, 64'd7, -64'sd2, 0, 1'b0);
        do_op(1'b0, 1'b1, -64'sd7, -64'sd2, 0, 1'b0);
        do_op(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, 1'b0);
        do_op(1'b0, 1'b0, 64'd12345, 64'd0, 0, 1'b0);
        do_op(1'b0, 1'b0, 64'd100, 64'd7, 0, 1'b0);
        do_op(1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
        do_op(1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'd0, 0, 1'b0);
        // Second start mid-CALC is ignored; abort together with start loses to start
        do_op(1'b0, 1'b0, 64'd100, 64'd7, 20, 1'b0);
        do_op(1'b0, 1'b1, -64'sd1000, 64'd33, 0, 1'b1);
        // Abort in CALC and in FIX keeps the 100/7 results
        do_op(1'b0, 1'b0, 64'd100, 64'd7, 0, 1'b0);
        abort_test(10, 64'd14, 64'd2);
        abort_test(64, 64'd14, 64'd2);

        // Reset in the middle of CALC clears everything asynchronously
        @(negedge clk);
        sel8     = 1'b0;
        dividend = 64'd5000;
        divisor  = 64'd9;
        start_a  = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy", 64'(busy_a), 64'd0);
        check_val("midrst_done", 64'(done_a), 64'd0);
        check_val("midrst_q", q_a, 64'd0);
        check_val("midrst_r", r_a, 64'd0);
        check_val("midrst_dbz", 64'(dbz_a), 64'd0);
        check_val("midrst_ovf", 64'(ovf_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed 8-bit boundaries
        do_op(1'b1, 1'b1, 64'h80, 64'hFF, 0, 1'b0);
        do_op(1'b1, 1'b0, 64'hFF, 64'd2, 0, 1'b0);
        do_op(1'b1, 1'b1, 64'h85, 64'd0, 0, 1'b0);

        // Random operations on both widths
        for (int i = 0; i < 100; i++) begin
            ra   = {$urandom, $urandom};
            mode = int'($urandom_range(0, 7));
            case (mode)
                0:       rb = 64'd0;
                1, 2:    rb = 64'($urandom_range(1, 20));
                3:       rb = -64'($urandom_range(1, 20));
                4:       rb = {$urandom, $urandom} >> $urandom_range(0, 63);
                default: rb = {$urandom, $urandom};
            endcase
            if (rb == 64'd0 && mode != 0) rb = 64'd1;
            do_op(i >= 40, 1'($urandom), ra, rb, 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
